// File: rtl/trig_acceptor_pkg.sv
// trig_acceptor_pkg
//   Shared definitions for the trigger acceptor: default record layout
//   (trigger number over timestamp), acceptor state encoding and the
//   saturation limit of the lost-trigger counter.
package trig_acceptor_pkg;

    localparam int unsigned TNBITS = 12;
    localparam int unsigned TSBITS = 20;
    localparam int unsigned REC_W  = TNBITS + TSBITS;

    localparam logic [15:0] LOST_MAX = 16'hFFFF;

    typedef enum logic {
        IDLE = 1'b0,
        DEAD = 1'b1
    } state_t;

endpackage

// File: rtl/trig_rec_fifo.sv
// trig_rec_fifo
//   Synchronous show-ahead FIFO holding accepted trigger records.
//   The head entry is presented on dout whenever the FIFO is not empty;
//   dout reads as zero while empty. DEPTH must be a power of two, >= 2.
// Ports:
//   clk    - clock
//   rst    - synchronous active-high reset (flushes the FIFO)
//   push   - write din at this edge (ignored when full)
//   din    - record to write
//   pop    - drop the head entry at this edge (ignored when empty)
//   dout   - head record
//   full   - DEPTH entries stored
//   empty  - no entries stored
//   count  - number of entries stored
module trig_rec_fifo #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    import trig_acceptor_pkg::*;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; emptiness alone decides what dout shows.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= din;
        end
    end

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = empty ? '0 : r_mem[r_rd];

endmodule

// File: rtl/trig_acceptor.sv
// trig_acceptor
//   Consumer side of the channel-pair trigger path. Accepts trig pulses
//   when idle, enabled and the record FIFO has room, enforces a dead time,
//   drives the registered inhibit back to the discriminators, counts
//   rejected triggers and buffers {tnum, tstamp} records for downstream.
//   Optional feature macro: TRIG_PRESCALE_EN (adds the prescale port and
//   accepts only every (prescale+1)-th eligible trigger).
// Ports:
//   ADCCLK    - single clock
//   reset     - synchronous active-high reset
//   enable    - acceptance enable
//   trig      - one-cycle trigger pulse
//   deadtime  - dead time in ADCCLK cycles (0 behaves as 1)
//   prescale  - prescale ratio minus one (TRIG_PRESCALE_EN only)
//   inhibit   - registered inhibit to the discriminators
//   rec_data  - head record {tnum, tstamp}
//   rec_valid - head record valid
//   rec_ready - downstream accepts head record
//   lost      - saturating count of rejected triggers
module trig_acceptor #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TSBITS = trig_acceptor_pkg::TSBITS,
    parameter int unsigned TNBITS = trig_acceptor_pkg::TNBITS
) (
    input  logic                     ADCCLK,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     trig,
    input  logic [15:0]              deadtime,
`ifdef TRIG_PRESCALE_EN
    input  logic [7:0]               prescale,
`endif
    output logic                     inhibit,
    output logic [TNBITS+TSBITS-1:0] rec_data,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [15:0]              lost
);
    import trig_acceptor_pkg::*;

    localparam int unsigned RW = TNBITS + TSBITS;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_t            r_state;
    state_t            w_state_next;
    logic [15:0]       r_dcnt;
    logic [15:0]       w_dcnt_next;
    logic [15:0]       w_dead_load;
    logic [TSBITS-1:0] r_ts;
    logic [TNBITS-1:0] r_tnum;
    logic [15:0]       r_lost;
    logic              r_inhibit;

    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic              w_elig;
    logic              w_pass;
    logic              w_push;
    logic              w_pop;
    logic              w_reject;
    logic              w_full_next;
    logic [RW-1:0]     w_rec_in;

    assign w_dead_load = (deadtime == 16'd0) ? 16'd1 : deadtime;

    // Fullness is sampled before any pop in the same cycle.
    assign w_elig   = trig & enable & (r_state == IDLE) & ~w_full;
    assign w_push   = w_elig & w_pass;
    assign w_reject = trig & enable & ~w_elig;
    assign w_pop    = ~w_empty & rec_ready;
    assign w_rec_in = {r_tnum, r_ts};

`ifdef TRIG_PRESCALE_EN
    logic [7:0] r_pcnt;

    // Counts eligible triggers modulo (prescale+1); a zero count passes.
    always_ff @(posedge ADCCLK) begin
        if (reset || !enable) begin
            r_pcnt <= '0;
        end else if (w_elig) begin
            r_pcnt <= (r_pcnt >= prescale) ? 8'd0 : r_pcnt + 8'd1;
        end
    end

    assign w_pass = (r_pcnt == 8'd0);
`else
    assign w_pass = 1'b1;
`endif

    // Push never happens while full, so occupancy after the edge reaches
    // DEPTH either by staying full without a pop or by a lone push at DEPTH-1.
    assign w_full_next = (w_count == CW'(DEPTH)) ? ~w_pop
                       : (w_push & ~w_pop & (w_count == CW'(DEPTH - 1)));

    always_ff @(posedge ADCCLK) begin
        if (reset) begin
            r_state <= IDLE;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_dcnt  <= w_dcnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_dcnt_next  = r_dcnt;
        case (r_state)
            IDLE: begin
                if (w_push) begin
                    w_state_next = DEAD;
                    w_dcnt_next  = w_dead_load;
                end
            end
            DEAD: begin
                if (!enable || r_dcnt <= 16'd1) begin
                    w_state_next = IDLE;
                    w_dcnt_next  = '0;
                end else begin
                    w_dcnt_next = r_dcnt - 16'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_dcnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge ADCCLK) begin
        if (reset) begin
            r_ts      <= '0;
            r_tnum    <= '0;
            r_lost    <= '0;
            r_inhibit <= 1'b0;
        end else begin
            r_ts <= r_ts + TSBITS'(1);
            if (w_push) begin
                r_tnum <= r_tnum + TNBITS'(1);
            end
            if (w_reject && (r_lost != LOST_MAX)) begin
                r_lost <= r_lost + 16'd1;
            end
            r_inhibit <= (w_state_next == DEAD) | w_full_next | ~enable;
        end
    end

    trig_rec_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (ADCCLK),
        .rst   (reset),
        .push  (w_push),
        .din   (w_rec_in),
        .pop   (w_pop),
        .dout  (rec_data),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign rec_valid = ~w_empty;
    assign inhibit   = r_inhibit;
    assign lost      = r_lost;

endmodule

// File: tb/tb_trig_acceptor.sv
// tb_trig_acceptor
//   Self-checking bench for trig_acceptor: a cycle table for the basic
//   dead-time scenario, hand-written corner sequences, and a randomized run
//   compared every cycle against a queue-based reference model.
module tb_trig_acceptor;

    localparam int TNB   = 12;
    localparam int TSB   = 20;
    localparam int REC_W = TNB + TSB;
    localparam int DEPTH = 8;

    logic              ADCCLK = 1'b0;
    logic              reset;
    logic              enable;
    logic              trig;
    logic [15:0]       deadtime;
`ifdef TRIG_PRESCALE_EN
    logic [7:0]        prescale;
`endif
    logic              inhibit;
    logic [REC_W-1:0]  rec_data;
    logic              rec_valid;
    logic              rec_ready;
    logic [15:0]       lost;

    trig_acceptor #(
        .DEPTH  (DEPTH),
        .TSBITS (TSB),
        .TNBITS (TNB)
    ) dut (
        .ADCCLK    (ADCCLK),
        .reset     (reset),
        .enable    (enable),
        .trig      (trig),
        .deadtime  (deadtime),
`ifdef TRIG_PRESCALE_EN
        .prescale  (prescale),
`endif
        .inhibit   (inhibit),
        .rec_data  (rec_data),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .lost      (lost)
    );

    always #5 ADCCLK = ~ADCCLK;

    int errors = 0;
    int checks = 0;
    int tc     = 0;

    // Reference model: absolute cycle bookkeeping plus a record queue.
    longint           m_cyc     = 0;
    longint           m_idle_at = 0;
    int               m_ts      = 0;
    int               m_tnum    = 0;
    int               m_lost    = 0;
    int               m_elig    = 0;
    bit               m_inh     = 1'b0;
    bit [REC_W-1:0]   q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, tc, $time);
        end
    endtask

    task automatic model_edge();
        bit full_b;
        bit elig;
        bit acc;
        bit pop;
        int d;
        if (reset) begin
            q.delete();
            m_ts = 0; m_tnum = 0; m_lost = 0; m_elig = 0;
            m_idle_at = 0; m_inh = 1'b0;
            m_cyc++;
            return;
        end
        d      = (deadtime == 16'd0) ? 1 : int'(deadtime);
        full_b = (q.size() == DEPTH);
        pop    = (q.size() != 0) && rec_ready;
        elig   = trig && enable && (m_cyc >= m_idle_at) && !full_b;
        acc    = elig;
`ifdef TRIG_PRESCALE_EN
        if (elig) begin
            acc = ((m_elig % (int'(prescale) + 1)) == 0);
            m_elig++;
        end
        if (!enable) m_elig = 0;
`endif
        if (trig && enable && !elig && m_lost < 65535) m_lost++;
        if (pop) void'(q.pop_front());
        if (acc) begin
            q.push_back({m_tnum[TNB-1:0], m_ts[TSB-1:0]});
            m_tnum    = (m_tnum + 1) % (1 << TNB);
            m_idle_at = m_cyc + d + 1;
        end
        if (!enable) m_idle_at = 0;
        m_inh = (m_cyc + 1 < m_idle_at) || (q.size() == DEPTH) || !enable;
        m_ts  = (m_ts + 1) % (1 << TSB);
        m_cyc++;
    endtask

    task automatic model_check();
        bit [REC_W-1:0] head;
        head = (q.size() != 0) ? q[0] : '0;
        chk("m_inhibit", {63'd0, inhibit}, {63'd0, m_inh});
        chk("m_rec_valid", {63'd0, rec_valid}, {63'd0, (q.size() != 0)});
        chk("m_rec_data", 64'(rec_data), 64'(head));
        chk("m_lost", 64'(lost), 64'(m_lost));
    endtask

    task automatic cyc();
        model_check();
        @(posedge ADCCLK);
        model_edge();
        #1;
        tc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge ADCCLK);
        model_edge();
        #1;
        reset = 1'b0;
        tc = 0;
    endtask

    task automatic step_to(input int c);
        while (tc < c) cyc();
    endtask

    typedef struct {
        bit             trig;
        bit             inh;
        bit             val;
        bit [REC_W-1:0] data;
        bit [15:0]      lost;
    } vec_t;

    vec_t tbl [19];

    initial begin
        reset = 1'b1; enable = 1'b1; trig = 1'b0; rec_ready = 1'b1; deadtime = 16'd5;
`ifdef TRIG_PRESCALE_EN
        prescale = 8'd0;
`endif
        // Dead-time scenario: deadtime=5, rec_ready=1, trig at 10, 13, 16.
        for (int c = 0; c < 19; c++) begin
            tbl[c].trig = 1'b0; tbl[c].inh = 1'b0; tbl[c].val = 1'b0;
            tbl[c].data = '0;   tbl[c].lost = 16'd0;
        end
        tbl[10].trig = 1'b1; tbl[13].trig = 1'b1; tbl[16].trig = 1'b1;
        for (int c = 11; c <= 15; c++) tbl[c].inh = 1'b1;
        tbl[17].inh = 1'b1; tbl[18].inh = 1'b1;
        tbl[11].val = 1'b1; tbl[11].data = {12'd0, 20'd10};
        tbl[17].val = 1'b1; tbl[17].data = {12'd1, 20'd16};
        for (int c = 14; c <= 18; c++) tbl[c].lost = 16'd1;

        do_reset();
        chk("reset_inhibit", {63'd0, inhibit}, 64'd0);
        chk("reset_valid", {63'd0, rec_valid}, 64'd0);
        chk("reset_data", 64'(rec_data), 64'd0);
        chk("reset_lost", 64'(lost), 64'd0);
        for (int c = 0; c < 19; c++) begin
            trig = tbl[c].trig;
            chk("tbl_inhibit", {63'd0, inhibit}, {63'd0, tbl[c].inh});
            chk("tbl_valid", {63'd0, rec_valid}, {63'd0, tbl[c].val});
            chk("tbl_data", 64'(rec_data), 64'(tbl[c].data));
            chk("tbl_lost", 64'(lost), 64'(tbl[c].lost));
            cyc();
        end
        trig = 1'b0;

        // FIFO fill: deadtime=1, no pops, trig every 3 cycles.
        deadtime = 16'd1; rec_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step_to(2 + 3 * k); trig = 1'b1; cyc(); trig = 1'b0;
        end
        chk("full_inhibit", {63'd0, inhibit}, 64'd1);
        step_to(26); trig = 1'b1; cyc(); trig = 1'b0;
        step_to(29); trig = 1'b1; cyc(); trig = 1'b0;
        chk("full_lost", 64'(lost), 64'd2);
        chk("full_inhibit_held", {63'd0, inhibit}, 64'd1);
        chk("full_head", 64'(rec_data), 64'({12'd0, 20'd2}));
        rec_ready = 1'b1; trig = 1'b1;
        cyc();
        rec_ready = 1'b0; trig = 1'b0;
        chk("pop_inhibit_drop", {63'd0, inhibit}, 64'd0);
        chk("pop_same_cycle_lost", 64'(lost), 64'd3);
        chk("pop_next_head", 64'(rec_data), 64'({12'd1, 20'd5}));
        trig = 1'b1; cyc(); trig = 1'b0;
        chk("refill_inhibit", {63'd0, inhibit}, 64'd1);
        cyc();

        // deadtime=0 behaves as 1: trig at 20 and 21 and 22.
        deadtime = 16'd0; rec_ready = 1'b1;
        do_reset();
        step_to(20); trig = 1'b1; cyc();
        chk("dt0_rec0", 64'(rec_data), 64'({12'd0, 20'd20}));
        chk("dt0_inhibit", {63'd0, inhibit}, 64'd1);
        cyc();
        chk("dt0_lost", 64'(lost), 64'd1);
        chk("dt0_inhibit_low", {63'd0, inhibit}, 64'd0);
        cyc(); trig = 1'b0;
        chk("dt0_rec1", 64'(rec_data), 64'({12'd1, 20'd22}));
        cyc();

        // Reset mid-operation: 3 records stored and DEAD.
        deadtime = 16'd10; rec_ready = 1'b0;
        do_reset();
        step_to(2);  trig = 1'b1; cyc(); trig = 1'b0;
        step_to(5);  trig = 1'b1; cyc(); trig = 1'b0;
        step_to(14); trig = 1'b1; cyc(); trig = 1'b0;
        step_to(26); trig = 1'b1; cyc(); trig = 1'b0;
        chk("pre_rst_valid", {63'd0, rec_valid}, 64'd1);
        chk("pre_rst_lost", 64'(lost), 64'd1);
        chk("pre_rst_inhibit", {63'd0, inhibit}, 64'd1);
        reset = 1'b1; cyc(); reset = 1'b0; tc = 0;
        chk("post_rst_valid", {63'd0, rec_valid}, 64'd0);
        chk("post_rst_inhibit", {63'd0, inhibit}, 64'd0);
        chk("post_rst_lost", 64'(lost), 64'd0);
        step_to(3); trig = 1'b1; cyc(); trig = 1'b0;
        chk("post_rst_rec", 64'(rec_data), 64'({12'd0, 20'd3}));
        cyc();

`ifdef TRIG_PRESCALE_EN
        // Prescale=2: of 9 eligible triggers only 1, 4, 7 are recorded.
        prescale = 8'd2; deadtime = 16'd1; rec_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step_to(2 + 3 * k); trig = 1'b1; cyc(); trig = 1'b0;
            chk("ps_valid", {63'd0, rec_valid}, {63'd0, (k % 3 == 0)});
            if (k % 3 == 0)
                chk("ps_rec", 64'(rec_data), 64'({12'(k / 3), 20'(2 + 3 * k)}));
        end
        chk("ps_lost", 64'(lost), 64'd0);
        cyc();
`endif

        // Randomized run against the reference model.
        rec_ready = 1'b1; enable = 1'b1; deadtime = 16'd3;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset  = ($urandom_range(0, 499) == 0);
            enable = ($urandom_range(0, 39) != 0);
            if (!enable) begin
                deadtime = 16'($urandom_range(0, 6));
`ifdef TRIG_PRESCALE_EN
                prescale = 8'($urandom_range(0, 3));
`endif
            end
            trig = ($urandom_range(0, 2) == 0);
            if (((i / 200) % 2) == 1) rec_ready = ($urandom_range(0, 9) < 3);
            else                      rec_ready = ($urandom_range(0, 9) < 8);
            cyc();
        end
        reset = 1'b0; trig = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
